gmii_buffer: RTL and testbench

// - Store-and-forward frame buffer between a GMII-style byte receiver and a

---
 rtl/gmii_buffer.sv | 204 ++++++++++++++++++++
 tb/tb_gmii_buffer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_buffer.sv
`default_nettype none
// ============================================================================
// gmii_buffer : store-and-forward frame buffer, GMII bytes in, ready/valid out
// Revision    : 1.0
// ============================================================================
module gmii_buffer #(
   parameter int unsigned DATA_DEPTH  = 4096,
   parameter int unsigned FRAME_DEPTH = 64
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic [7:0] Input_data,
   input  logic       Input_valid,
   input  logic       Input_error,
   output logic       Input_accepted,
   output logic [7:0] Output_data,
   output logic       Output_valid,
   output logic       Output_last,
   input  logic       Output_ready
);

   localparam int unsigned c_AW = $clog2(DATA_DEPTH);
   localparam int unsigned c_PW = c_AW + 1;
   localparam int unsigned c_FW = $clog2(FRAME_DEPTH) + 1;
   localparam logic [c_PW-1:0] c_DEPTH  = c_PW'(DATA_DEPTH);
   localparam logic [c_FW-1:0] c_FDEPTH = c_FW'(FRAME_DEPTH);

   // frame storage, one {last, data} word per byte
   logic [8:0]      mem_q [DATA_DEPTH];

   logic            in_prev_q;
   logic            err_q, err_d;
   logic            ovf_q, ovf_d;
   logic            qfull_q, qfull_d;
   logic            acc_q, acc_d;
   logic [c_PW-1:0] wr_spec_q, wr_spec_d;
   logic [c_PW-1:0] wr_commit_q, wr_commit_d;
   logic [c_PW-1:0] len_q, len_d;
   logic [c_PW-1:0] used_q, used_d;
   logic [c_FW-1:0] pend_q, pend_d;
   logic [7:0]      last_byte_q, last_byte_d;

   logic [c_PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [c_PW-1:0] out_cnt_q, out_cnt_d;
   logic            rd_vld_q;
   logic [8:0]      rd_word_q;
   logic            out_v_q, out_v_d;
   logic [8:0]      out_w_q, out_w_d;
   logic            skid_v_q, skid_v_d;
   logic [8:0]      skid_w_q, skid_w_d;

   logic            w_first, w_frame_end, w_no_space, w_byte_we, w_commit;
   logic [c_PW-1:0] w_len_eff, w_last_addr, w_added, w_freed, w_unread;
   logic [c_PW:0]   w_fill;
   logic [1:0]      w_occ;
   logic            w_pop, w_free, w_issue;
   logic            w_mem_we;
   logic [c_AW-1:0] w_mem_waddr;
   logic [8:0]      w_mem_wdata;

   // ---------------------------------------------------------------- write side
   always_comb begin
      w_first     = Input_valid && !in_prev_q;
      w_frame_end = !Input_valid && in_prev_q;
      w_len_eff   = w_first ? '0 : len_q;
      w_fill      = {1'b0, used_q} + {1'b0, w_len_eff};
      w_no_space  = (w_fill >= {1'b0, c_DEPTH});

      err_d   = err_q;
      ovf_d   = ovf_q;
      qfull_d = qfull_q;
      if (w_first) begin
         err_d   = Input_error;
         ovf_d   = w_no_space;
         qfull_d = (pend_q == c_FDEPTH);
      end else if (Input_valid) begin
         err_d = err_q | Input_error;
         ovf_d = ovf_q | w_no_space;
      end

      // Bytes are only stored while the frame is still good; a dropped frame
      // therefore never consumes space past the byte that killed it.
      w_byte_we   = Input_valid && !(err_d || ovf_d || qfull_d);
      w_commit    = w_frame_end && !(err_q || ovf_q || qfull_q);
      acc_d       = Input_valid ? w_byte_we : acc_q;
      len_d       = w_len_eff + c_PW'(w_byte_we);
      last_byte_d = w_byte_we ? Input_data : last_byte_q;

      wr_spec_d   = wr_spec_q + c_PW'(w_byte_we);
      wr_commit_d = wr_commit_q;
      if (w_commit) begin
         wr_commit_d = wr_spec_q;
      end else if (w_frame_end) begin
         wr_spec_d = wr_commit_q;
      end

      // The end cycle carries no input byte, so the write port is free for
      // rewriting the final byte with its last marker set.
      w_last_addr = wr_spec_q - c_PW'(1);
      w_mem_we    = w_byte_we || w_commit;
      w_mem_waddr = w_commit ? w_last_addr[c_AW-1:0] : wr_spec_q[c_AW-1:0];
      w_mem_wdata = w_commit ? {1'b1, last_byte_q} : {1'b0, Input_data};
   end

   // ----------------------------------------------------------------- read side
   always_comb begin
      w_unread = wr_commit_q - rd_ptr_q;
      w_pop    = out_v_q && Output_ready;
      w_free   = w_pop && out_w_q[8];
      w_occ    = {1'b0, out_v_q} + {1'b0, skid_v_q} + {1'b0, rd_vld_q};
      // Two output slots: words in flight from the RAM count as occupied.
      w_issue  = (w_unread != '0) && ((w_occ < 2'd2) || w_pop);
      rd_ptr_d = rd_ptr_q + c_PW'(w_issue);

      out_v_d  = out_v_q;
      out_w_d  = out_w_q;
      skid_v_d = skid_v_q;
      skid_w_d = skid_w_q;
      if (!out_v_q || w_pop) begin
         if (skid_v_q) begin
            out_v_d  = 1'b1;
            out_w_d  = skid_w_q;
            skid_v_d = rd_vld_q;
            skid_w_d = rd_word_q;
         end else begin
            out_v_d = rd_vld_q;
            out_w_d = rd_vld_q ? rd_word_q : '0;
         end
      end else if (rd_vld_q) begin
         skid_v_d = 1'b1;
         skid_w_d = rd_word_q;
      end

      out_cnt_d = out_cnt_q;
      if (w_pop) begin
         out_cnt_d = w_free ? '0 : out_cnt_q + c_PW'(1);
      end

      w_added = w_commit ? len_q : '0;
      w_freed = w_free ? out_cnt_q + c_PW'(1) : '0;
      used_d  = used_q + w_added - w_freed;
      pend_d  = pend_q + c_FW'(w_commit) - c_FW'(w_free);
   end

   // ----------------------------------------------------------------- registers
   always_ff @(posedge Clk) begin
      if (Rst) begin
         // A frame already in progress at reset is swallowed until the line idles.
         in_prev_q   <= Input_valid;
         err_q       <= 1'b1;
         ovf_q       <= 1'b0;
         qfull_q     <= 1'b0;
         acc_q       <= 1'b0;
         wr_spec_q   <= '0;
         wr_commit_q <= '0;
         len_q       <= '0;
         used_q      <= '0;
         pend_q      <= '0;
         last_byte_q <= '0;
         rd_ptr_q    <= '0;
         out_cnt_q   <= '0;
         rd_vld_q    <= 1'b0;
         out_v_q     <= 1'b0;
         out_w_q     <= '0;
         skid_v_q    <= 1'b0;
         skid_w_q    <= '0;
      end else begin
         in_prev_q   <= Input_valid;
         err_q       <= err_d;
         ovf_q       <= ovf_d;
         qfull_q     <= qfull_d;
         acc_q       <= acc_d;
         wr_spec_q   <= wr_spec_d;
         wr_commit_q <= wr_commit_d;
         len_q       <= len_d;
         used_q      <= used_d;
         pend_q      <= pend_d;
         last_byte_q <= last_byte_d;
         rd_ptr_q    <= rd_ptr_d;
         out_cnt_q   <= out_cnt_d;
         rd_vld_q    <= w_issue;
         out_v_q     <= out_v_d;
         out_w_q     <= out_w_d;
         skid_v_q    <= skid_v_d;
         skid_w_q    <= skid_w_d;
      end
   end

   always_ff @(posedge Clk) begin
      if (w_mem_we) begin
         mem_q[w_mem_waddr] <= w_mem_wdata;
      end
      if (w_issue) begin
         rd_word_q <= mem_q[rd_ptr_q[c_AW-1:0]];
      end
   end

   assign Input_accepted = acc_q;
   assign Output_valid   = out_v_q;
   assign Output_data    = out_w_q[7:0];
   assign Output_last    = out_w_q[8];

endmodule
`default_nettype wire

// File: tb/tb_gmii_buffer.sv
`default_nettype none
// ============================================================================
// tb_gmii_buffer : directed frame table, corner sequences and random traffic
// Revision       : 1.0
// ============================================================================
module tb_gmii_buffer;

   localparam int DEPTH  = 4096;
   localparam int FDEPTH = 64;

   logic       Clk = 1'b0;
   logic       Rst = 1'b1;
   logic [7:0] Input_data = '0;
   logic       Input_valid = 1'b0;
   logic       Input_error = 1'b0;
   logic       Input_accepted;
   logic [7:0] Output_data;
   logic       Output_valid;
   logic       Output_last;
   logic       Output_ready = 1'b0;

   always #5 Clk = ~Clk;

   gmii_buffer #(.DATA_DEPTH(DEPTH), .FRAME_DEPTH(FDEPTH)) dut (
      .Clk(Clk), .Rst(Rst),
      .Input_data(Input_data), .Input_valid(Input_valid), .Input_error(Input_error),
      .Input_accepted(Input_accepted),
      .Output_data(Output_data), .Output_valid(Output_valid), .Output_last(Output_last),
      .Output_ready(Output_ready)
   );

   int checks = 0;
   int errors = 0;
   int ready_pct = 100;
   int frames_out = 0;

   // reference model: committed bytes awaiting output and their frame lengths
   logic [8:0] exp_q[$];
   int         flen_q[$];
   logic [7:0] cur_q[$];
   int         used_m = 0;
   int         pend_m = 0;
   bit         prev_m = 0, discard_m = 0, bad_m = 0, acc_m = 0, acc_known = 0;
   logic [8:0] mon_w;

   typedef struct {
      int         len;
      int         err_at;
      logic [7:0] base;
      int         exp_acc;
   } vec_t;
   vec_t vecs[4];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   always @(posedge Clk) begin
      #1;
      Output_ready = ($urandom_range(0, 99) < ready_pct);
   end

   // Model evaluates, on each falling edge, what the coming rising edge does.
   always @(negedge Clk) begin
      if (acc_known) check("accepted", int'(Input_accepted), int'(acc_m));
      if (Rst) begin
         exp_q.delete();
         flen_q.delete();
         cur_q.delete();
         used_m    = 0;
         pend_m    = 0;
         acc_m     = 0;
         bad_m     = 0;
         prev_m    = Input_valid;
         discard_m = Input_valid;
         acc_known = !Input_valid;
      end else begin
         if (Input_valid) begin
            if (!prev_m) begin
               discard_m = 0;
               cur_q.delete();
               bad_m = Input_error || (pend_m == FDEPTH) || (used_m >= DEPTH);
            end else begin
               bad_m = bad_m || Input_error || (used_m + cur_q.size() >= DEPTH);
            end
            if (!discard_m) begin
               if (!bad_m) cur_q.push_back(Input_data);
               acc_m     = !bad_m;
               acc_known = 1;
            end
         end
         if (Output_valid && Output_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got byte %0d last %0d, want no output",
                        Output_data, Output_last);
            end else begin
               mon_w = exp_q.pop_front();
               check("out_data", int'(Output_data), int'(mon_w[7:0]));
               check("out_last", int'(Output_last), int'(mon_w[8]));
               if (mon_w[8] && flen_q.size() != 0) begin
                  used_m -= flen_q.pop_front();
                  pend_m--;
               end
            end
            if (Output_last) frames_out++;
         end
         if (!Input_valid && prev_m) begin
            if (!discard_m && !bad_m) begin
               for (int i = 0; i < cur_q.size(); i++)
                  exp_q.push_back({(i == cur_q.size() - 1), cur_q[i]});
               flen_q.push_back(cur_q.size());
               used_m += cur_q.size();
               pend_m++;
            end
            discard_m = 0;
         end
         prev_m = Input_valid;
      end
   end

   // Returns just after the edge that samples the last byte; the idle
   // (end) cycle is being presented at that point.
   task automatic send_frame(input int len, input int err_at, input logic [7:0] base,
                             input int step, input int rst_at);
      for (int i = 0; i < len; i++) begin
         @(posedge Clk);
         #1;
         Rst         = (i == rst_at);
         Input_valid = 1'b1;
         Input_data  = 8'(int'(base) + step * i);
         Input_error = (i == err_at);
      end
      @(posedge Clk);
      #1;
      Rst         = 1'b0;
      Input_valid = 1'b0;
      Input_error = 1'b0;
   endtask

   task automatic wait_drain(input string name, input int budget);
      int n;
      n = 0;
      repeat (2) @(negedge Clk);
      while ((exp_q.size() != 0 || Output_valid) && n < budget) begin
         @(negedge Clk);
         n++;
      end
      check(name, exp_q.size(), 0);
      repeat (8) @(negedge Clk);
   endtask

   initial begin
      #(95000 * 10);
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int f0, len, err_at, gap;
      vecs[0] = '{3, -1, 8'd11, 1};
      vecs[1] = '{5,  0, 8'd50, 0};
      vecs[2] = '{5,  4, 8'd60, 0};
      vecs[3] = '{4, -1, 8'd70, 1};

      repeat (3) @(posedge Clk);
      @(negedge Clk);
      check("reset_valid", int'(Output_valid), 0);
      check("reset_last", int'(Output_last), 0);
      check("reset_acc", int'(Input_accepted), 0);
      @(posedge Clk);
      #1;
      Rst = 1'b0;
      repeat (2) @(posedge Clk);

      ready_pct = 100;
      for (int k = 0; k < 4; k++) begin
         f0 = frames_out;
         send_frame(vecs[k].len, vecs[k].err_at, vecs[k].base, 11, -1);
         check($sformatf("vec%0d_acc", k), int'(Input_accepted), vecs[k].exp_acc);
         wait_drain($sformatf("vec%0d_drain", k), 200);
         check($sformatf("vec%0d_frames", k), frames_out - f0, vecs[k].exp_acc);
      end

      // data RAM overflow: third frame cannot fit behind the first two
      ready_pct = 0;
      repeat (2) @(posedge Clk);
      f0 = frames_out;
      send_frame(1500, -1, 8'h10, 3, -1);
      check("ovf_acc0", int'(Input_accepted), 1);
      send_frame(1500, -1, 8'h20, 5, -1);
      check("ovf_acc1", int'(Input_accepted), 1);
      send_frame(1500, -1, 8'h30, 7, -1);
      check("ovf_acc2", int'(Input_accepted), 0);
      repeat (4) @(posedge Clk);
      ready_pct = 100;
      wait_drain("ovf_drain", 5000);
      check("ovf_frames", frames_out - f0, 2);

      // frame queue full
      ready_pct = 0;
      repeat (2) @(posedge Clk);
      f0 = frames_out;
      for (int k = 0; k <= FDEPTH; k++) begin
         send_frame(1, -1, 8'(k), 1, -1);
         if (k == 0 || k == FDEPTH - 1 || k == FDEPTH)
            check($sformatf("qfull_acc%0d", k), int'(Input_accepted), (k < FDEPTH) ? 1 : 0);
      end
      repeat (4) @(posedge Clk);
      ready_pct = 100;
      wait_drain("qfull_drain", 1000);
      check("qfull_frames", frames_out - f0, FDEPTH);

      // reset in the middle of an input frame
      f0 = frames_out;
      send_frame(20, -1, 8'h40, 1, 10);
      wait_drain("rst_in_drain", 100);
      check("rst_in_frames", frames_out - f0, 0);
      f0 = frames_out;
      send_frame(6, -1, 8'h50, 13, -1);
      check("rst_in_fresh_acc", int'(Input_accepted), 1);
      wait_drain("rst_in_fresh_drain", 100);
      check("rst_in_fresh_frames", frames_out - f0, 1);

      // reset in the middle of an output frame with another frame queued
      ready_pct = 0;
      send_frame(40, -1, 8'h60, 3, -1);
      send_frame(10, -1, 8'h90, 5, -1);
      repeat (6) @(posedge Clk);
      ready_pct = 100;
      repeat (12) @(posedge Clk);
      #1;
      Rst = 1'b1;
      @(posedge Clk);
      #1;
      Rst = 1'b0;
      check("rst_out_valid", int'(Output_valid), 0);
      f0 = frames_out;
      repeat (30) @(negedge Clk);
      check("rst_out_frames", frames_out - f0, 0);
      f0 = frames_out;
      send_frame(8, -1, 8'hA0, 9, -1);
      check("rst_out_fresh_acc", int'(Input_accepted), 1);
      wait_drain("rst_out_fresh_drain", 100);
      check("rst_out_fresh_frames", frames_out - f0, 1);

      // randomized traffic
      for (int f = 0; f < 200; f++) begin
         ready_pct = (f < 100) ? 80 : 10;
         len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 1500))
                                           : int'($urandom_range(1, 64));
         err_at = ($urandom_range(0, 99) < 5) ? int'($urandom_range(0, len - 1)) : -1;
         send_frame(len, err_at, 8'($urandom), int'($urandom_range(1, 255)), -1);
         gap = ($urandom_range(0, 4) == 0) ? int'($urandom_range(100, 200))
                                           : int'($urandom_range(0, 5));
         repeat (gap) @(posedge Clk);
      end
      ready_pct = 100;
      wait_drain("random_drain", 20000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
